instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports clk and rst. All other ports are listed below.
REQ-002 Parameter ADDR_W, default 8: fetch address width, matching the program counter output.
REQ-003 Parameter DATA_W, default 32: instruction width.
REQ-004 Parameter TIMEOUT, default 15: maximum number of WAIT cycles without mem_ack before an error is raised; range 1..255.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  permits new fetch requests.
REQ-008 flush  input  1  discards any in-flight or held instruction.
REQ-009 pc_value  input  ADDR_W  current program counter value.
REQ-010 pc_inc  output  1  one-cycle strobe that advances the program counter.
REQ-011 mem_req  output  1  instruction memory read request.
REQ-012 mem_addr  output  ADDR_W  instruction memory read address.
REQ-013 mem_ack  input  1  memory response valid; mem_rdata is valid in the same cycle.
REQ-014 mem_rdata  input  DATA_W  instruction word returned by memory.
REQ-015 instr  output  DATA_W  fetched instruction.
REQ-016 instr_addr  output  ADDR_W  address of the fetched instruction.
REQ-017 instr_valid  output  1  instr and instr_addr are valid.
REQ-018 instr_ready  input  1  downstream accepts the instruction.
REQ-019 fetch_err  output  1  sticky memory-timeout error flag.

Function
REQ-020 All outputs SHALL be registered.
REQ-021 The block SHALL implement an FSM with the states IDLE, WAIT and FULL.
REQ-022 IDLE: if enable=1, flush=0 and fetch_err=0, the block SHALL latch pc_value into mem_addr, set mem_req=1 and enter WAIT; otherwise it SHALL stay in IDLE with mem_req=0.
REQ-023 WAIT: mem_req and mem_addr SHALL be held stable until mem_ack is sampled high.
REQ-024 WAIT, on mem_ack=1 and flush=0, the block SHALL in the next cycle:
  - set instr=mem_rdata, instr_addr=mem_addr and instr_valid=1;
  - set mem_req=0 and pulse pc_inc=1 for exactly one cycle;
  - enter FULL.
REQ-025 FULL: on instr_ready=1 the block SHALL set instr_valid=0 and enter IDLE; instr and instr_addr SHALL hold while instr_valid=1 and instr_ready=0.
REQ-026 Minimum latency SHALL be 2 cycles from pc_value sampled in IDLE to instr_valid=1, when mem_ack arrives in the first WAIT cycle.
REQ-027 Peak throughput SHALL be one instruction per 3 cycles.
REQ-028 Flush in IDLE SHALL suppress the request for that cycle.
REQ-029 Flush in WAIT SHALL set an internal drop flag; mem_req SHALL stay high until mem_ack.
REQ-030 The acknowledged data of a dropped request SHALL be discarded: no instr_valid, no pc_inc; the block SHALL then return to IDLE.
REQ-031 Flush and mem_ack in the same WAIT cycle SHALL discard the data.
REQ-032 Flush in FULL SHALL clear instr_valid and enter IDLE; flush together with instr_ready SHALL behave as flush alone.
REQ-033 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without mem_ack.
REQ-034 When the wait counter reaches TIMEOUT, the block SHALL set fetch_err=1, drop mem_req and enter IDLE.
REQ-035 fetch_err SHALL be sticky: once set, it SHALL clear only on rst and SHALL block all new requests.
REQ-036 mem_ack seen outside WAIT SHALL be ignored.
REQ-037 pc_inc SHALL fire exactly once per instruction delivered.
REQ-038 enable=0 SHALL affect only the IDLE decision; an outstanding request SHALL still complete.

Reset
REQ-039 Reset SHALL be synchronous, active-high, and take priority over all other inputs.
REQ-040 On reset: state=IDLE, and mem_req, pc_inc, instr_valid, fetch_err, the drop flag and the wait counter SHALL all be 0.
REQ-041 On reset, instr and mem_addr SHALL be all zeros and instr_addr SHALL be 0.
REQ-042 Reset asserted mid-WAIT or mid-FULL SHALL abandon the transaction without a pc_inc pulse.

Verification
REQ-043 Scenario: pc_value=8'h05, enable=1, mem_ack in the first WAIT cycle with mem_rdata=32'h2008000A -> instr_valid=1 two cycles after the IDLE sample, instr_addr=8'h05, instr=32'h2008000A, one pc_inc pulse.
REQ-044 Scenario: instr_ready held 0 for 4 cycles after valid -> instr and instr_valid stable and no new mem_req; instr_ready=1 -> IDLE the next cycle and a new request one cycle later.
REQ-045 Scenario: flush raised in the second WAIT cycle, mem_ack 2 cycles later -> no instr_valid, no pc_inc, return to IDLE, next request uses the current pc_value.
REQ-046 Scenario: TIMEOUT=3 and mem_ack never arrives -> fetch_err=1 after 3 WAIT cycles, mem_req=0, no further requests; rst -> fetch_err=0.
REQ-047 Scenario: flush and mem_ack in the same cycle, then flush and instr_ready in the same cycle while FULL -> the data is discarded in the first case and instr_valid clears exactly once in the second, with no extra pc_inc.
REQ-048 Scenario: rst asserted while in WAIT with mem_ack in the same cycle -> all outputs at reset values the next cycle and no pc_inc.

Source files
------------

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit: requests one word at the current PC,
// holds it for downstream, supports flush and a sticky memory-timeout error.
module instruction_fetch #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc_value,
    output logic              pc_inc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_err
);

    typedef enum logic [1:0] {StIdle, StWait, StFull} state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e            state_q;
    logic              drop_q;
    logic [7:0]        wait_cnt_q;
    logic              pc_inc_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] instr_addr_q;
    logic              instr_valid_q;
    logic              fetch_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            drop_q        <= 1'b0;
            wait_cnt_q    <= '0;
            pc_inc_q      <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            instr_q       <= '0;
            instr_addr_q  <= '0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            pc_inc_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (enable && !flush && !fetch_err_q) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_value;
                        wait_cnt_q <= '0;
                        drop_q     <= 1'b0;
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        // A flush now or earlier in this request discards the returned word
                        if (flush || drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            instr_q       <= mem_rdata;
                            instr_addr_q  <= mem_addr_q;
                            instr_valid_q <= 1'b1;
                            pc_inc_q      <= 1'b1;
                            state_q       <= StFull;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                        if (flush) begin
                            drop_q <= 1'b1;
                        end
                        if (wait_cnt_q == TimeoutLast) begin
                            fetch_err_q <= 1'b1;
                            mem_req_q   <= 1'b0;
                            state_q     <= StIdle;
                        end
                    end
                end
                StFull: begin
                    if (flush || instr_ready) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign pc_inc      = pc_inc_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_addr  = instr_addr_q;
    assign instr_valid = instr_valid_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: two instances (short and default timeout) driven with the
// same directed and random stimulus, each compared every cycle to a transaction-level model.
module tb_instruction_fetch;

    localparam int unsigned ToA = 3;
    localparam int unsigned ToB = 15;

    logic        clk = 1'b0;
    logic        rst, enable, flush, mem_ack, instr_ready;
    logic [7:0]  pc_value;
    logic [31:0] mem_rdata;

    logic        inc_a, req_a, vld_a, err_a;
    logic [7:0]  addr_a, iaddr_a;
    logic [31:0] ins_a;
    logic        inc_b, req_b, vld_b, err_b;
    logic [7:0]  addr_b, iaddr_b;
    logic [31:0] ins_b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        busy;   // a request is outstanding at the memory
        logic        drop;   // that request was flushed and must be thrown away
        logic        hold;   // an instruction is being offered downstream
        logic        err;
        logic        inc;
        logic [8:0]  waits;
        logic [7:0]  addr;
        logic [31:0] instr;
        logic [7:0]  iaddr;
    } model_t;

    model_t ma = '0;
    model_t mb = '0;

    always #5 clk = ~clk;

    instruction_fetch #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(ToA)) u_dut_a (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush), .pc_value(pc_value),
        .pc_inc(inc_a), .mem_req(req_a), .mem_addr(addr_a), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .instr(ins_a), .instr_addr(iaddr_a), .instr_valid(vld_a),
        .instr_ready(instr_ready), .fetch_err(err_a)
    );

    instruction_fetch #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(ToB)) u_dut_b (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush), .pc_value(pc_value),
        .pc_inc(inc_b), .mem_req(req_b), .mem_addr(addr_b), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .instr(ins_b), .instr_addr(iaddr_b), .instr_valid(vld_b),
        .instr_ready(instr_ready), .fetch_err(err_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic model_t model_next(model_t m, int unsigned to, logic rs, logic en,
                                          logic fl, logic [7:0] pc, logic ack,
                                          logic [31:0] rd, logic rdy);
        model_t n = m;
        n.inc = 1'b0;
        if (rs) begin
            n = '0;
        end else if (m.hold) begin
            if (fl || rdy) n.hold = 1'b0;
        end else if (m.busy) begin
            if (ack) begin
                n.busy = 1'b0;
                if (!(fl || m.drop)) begin
                    n.hold  = 1'b1;
                    n.instr = rd;
                    n.iaddr = m.addr;
                    n.inc   = 1'b1;
                end
            end else begin
                n.waits = m.waits + 9'd1;
                if (fl) n.drop = 1'b1;
                if (int'(n.waits) >= int'(to)) begin
                    n.err  = 1'b1;
                    n.busy = 1'b0;
                end
            end
        end else if (en && !fl && !m.err) begin
            n.busy  = 1'b1;
            n.addr  = pc;
            n.waits = '0;
            n.drop  = 1'b0;
        end
        return n;
    endfunction

    task automatic compare_dut(input string p, input model_t m, input logic req,
                               input logic [7:0] addr, input logic inc, input logic [31:0] ins,
                               input logic [7:0] iaddr, input logic vld, input logic err);
        check({p, "_mem_req"},     64'(req),   64'(m.busy));
        check({p, "_mem_addr"},    64'(addr),  64'(m.addr));
        check({p, "_pc_inc"},      64'(inc),   64'(m.inc));
        check({p, "_instr"},       64'(ins),   64'(m.instr));
        check({p, "_instr_addr"},  64'(iaddr), 64'(m.iaddr));
        check({p, "_instr_valid"}, 64'(vld),   64'(m.hold));
        check({p, "_fetch_err"},   64'(err),   64'(m.err));
    endtask

    // Called at a falling edge: apply inputs, advance both models, then compare after the edge.
    task automatic cycle(input logic rs, input logic en, input logic fl, input logic [7:0] pc,
                         input logic ack, input logic [31:0] rd, input logic rdy);
        rst = rs; enable = en; flush = fl; pc_value = pc;
        mem_ack = ack; mem_rdata = rd; instr_ready = rdy;
        ma = model_next(ma, ToA, rs, en, fl, pc, ack, rd, rdy);
        mb = model_next(mb, ToB, rs, en, fl, pc, ack, rd, rdy);
        @(posedge clk);
        @(negedge clk);
        compare_dut("a", ma, req_a, addr_a, inc_a, ins_a, iaddr_a, vld_a, err_a);
        compare_dut("b", mb, req_b, addr_b, inc_b, ins_b, iaddr_b, vld_b, err_b);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; flush = 1'b0; pc_value = '0;
        mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
        @(negedge clk);
        cycle(1, 0, 0, 8'h00, 0, 32'h0, 0);
        cycle(1, 0, 0, 8'h00, 0, 32'h0, 0);
        check("reset_mem_req", 64'(req_a), 64'd0);
        check("reset_instr", 64'(ins_a), 64'd0);

        // Minimum latency fetch at 0x05
        cycle(0, 1, 0, 8'h05, 0, 32'h0, 0);
        cycle(0, 1, 0, 8'h33, 1, 32'h2008000A, 0);
        check("lat_valid", 64'(vld_a), 64'd1);
        check("lat_instr", 64'(ins_a), 64'h2008000A);
        check("lat_iaddr", 64'(iaddr_a), 64'h05);
        check("lat_pc_inc", 64'(inc_a), 64'd1);

        // Backpressure for 4 cycles, stray acks ignored
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 8'h40, 1, $urandom, 0);
        check("hold_instr", 64'(ins_a), 64'h2008000A);
        check("hold_no_req", 64'(req_a), 64'd0);
        check("hold_pc_inc", 64'(inc_a), 64'd0);
        cycle(0, 1, 0, 8'h40, 0, 32'h0, 1);
        check("ready_clears_valid", 64'(vld_a), 64'd0);
        cycle(0, 1, 0, 8'h40, 0, 32'h0, 0);
        check("next_req", 64'(req_a), 64'd1);
        check("next_addr", 64'(addr_a), 64'h40);

        // Flush in second WAIT cycle, ack two cycles later (instance a times out first)
        cycle(0, 1, 0, 8'h41, 0, 32'h0, 0);
        cycle(0, 1, 1, 8'h42, 0, 32'h0, 0);
        cycle(0, 1, 0, 8'h43, 0, 32'h0, 0);
        check("timeout_err", 64'(err_a), 64'd1);
        check("timeout_req", 64'(req_a), 64'd0);
        cycle(0, 1, 0, 8'h44, 1, 32'hCAFEF00D, 0);
        check("drop_no_valid", 64'(vld_b), 64'd0);
        check("drop_no_inc", 64'(inc_b), 64'd0);
        cycle(0, 1, 0, 8'h77, 0, 32'h0, 0);
        check("after_drop_addr", 64'(addr_b), 64'h77);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'h50, 0, 32'h0, 0);
        check("err_blocks_req", 64'(req_a), 64'd0);
        cycle(1, 0, 0, 8'h00, 0, 32'h0, 0);
        check("err_cleared", 64'(err_a), 64'd0);

        // Flush with ack, then flush with ready while FULL
        cycle(0, 1, 0, 8'h10, 0, 32'h0, 0);
        cycle(0, 0, 1, 8'h10, 1, 32'h11111111, 0);
        check("flush_ack_valid", 64'(vld_a), 64'd0);
        cycle(0, 1, 0, 8'h11, 0, 32'h0, 0);
        cycle(0, 0, 0, 8'h11, 1, 32'hDEADBEEF, 0);
        check("full_valid", 64'(vld_a), 64'd1);
        cycle(0, 0, 1, 8'h11, 0, 32'h0, 1);
        check("flush_ready_valid", 64'(vld_a), 64'd0);
        check("flush_ready_inc", 64'(inc_a), 64'd0);
        cycle(0, 0, 0, 8'h11, 0, 32'h0, 0);

        // Reset with ack during WAIT
        cycle(0, 1, 0, 8'h20, 0, 32'h0, 0);
        cycle(1, 1, 0, 8'h20, 1, 32'h12345678, 1);
        check("rst_wait_inc", 64'(inc_a), 64'd0);
        check("rst_wait_valid", 64'(vld_a), 64'd0);
        check("rst_wait_addr", 64'(addr_a), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 8,
                  $urandom_range(0, 9) == 0, 8'($urandom), $urandom_range(0, 9) < 6,
                  $urandom, $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
